// File: rtl/ofifo_pkg.sv
// Shared sizing constants for the mac_row / ofifo datapath.
// Column status bundle used when gathering per-column FIFO flags.
package ofifo_pkg;

    localparam int COL          = 8;
    localparam int PSUM_BW      = 16;
    localparam int OFIFO_DEPTH  = 16;
    localparam int OFIFO_PTR_BW = 4;

    typedef struct packed {
        logic empty;
        logic full;
        logic drop;
    } col_status_t;

endpackage

// File: rtl/ofifo_col.sv
// Single-column psum FIFO with a combinational head and wrap-bit pointers.
// Pops must be pre-qualified by the caller; writes into a full column are dropped.
module ofifo_col
    import ofifo_pkg::*;
#(
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH,
    parameter int ptr_bw  = OFIFO_PTR_BW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [psum_bw-1:0] in,
    input  logic               wr,
    input  logic               rd,
    output logic [psum_bw-1:0] out,
    output logic               empty,
    output logic               full,
    output logic               drop
);

    logic [psum_bw-1:0] mem_q [depth];
    logic [ptr_bw:0]    wptr_q, wptr_d;
    logic [ptr_bw:0]    rptr_q, rptr_d;
    logic               wr_en;
    logic               rd_en;

    always_comb begin
        empty  = (wptr_q == rptr_q);
        full   = (wptr_q[ptr_bw] != rptr_q[ptr_bw]) &&
                 (wptr_q[ptr_bw-1:0] == rptr_q[ptr_bw-1:0]);
        // Full is judged on pre-edge pointers, so a same-cycle pop never rescues a write.
        wr_en  = wr & ~full;
        rd_en  = rd & ~empty;
        drop   = wr & full;
        wptr_d = wptr_q + {{ptr_bw{1'b0}}, wr_en};
        rptr_d = rptr_q + {{ptr_bw{1'b0}}, rd_en};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q[ptr_bw-1:0]] <= in;
        end
    end

    assign out = mem_q[rptr_q[ptr_bw-1:0]];

endmodule

// File: rtl/ofifo.sv
// Output FIFO behind mac_row: one FIFO per column absorbs the systolic skew,
// and a common pop re-aligns a full row of psums into a registered output.
module ofifo
    import ofifo_pkg::*;
#(
    parameter int col     = COL,
    parameter int psum_bw = PSUM_BW,
    parameter int depth   = OFIFO_DEPTH,
    parameter int ptr_bw  = OFIFO_PTR_BW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   overflow
);

    col_status_t [col-1:0]    status;
    logic [col-1:0]           empty_w;
    logic [col-1:0]           full_w;
    logic [col-1:0]           drop_w;
    logic [psum_bw*col-1:0]   head_w;
    logic [psum_bw*col-1:0]   out_q, out_d;
    logic                     overflow_q, overflow_d;
    logic                     pop;

    generate
        for (genvar gi = 0; gi < col; gi++) begin : g_col
            ofifo_col #(
                .psum_bw (psum_bw),
                .depth   (depth),
                .ptr_bw  (ptr_bw)
            ) u_col (
                .clk   (clk),
                .reset (reset),
                .in    (in[psum_bw*gi +: psum_bw]),
                .wr    (wr[gi]),
                .rd    (pop),
                .out   (head_w[psum_bw*gi +: psum_bw]),
                .empty (status[gi].empty),
                .full  (status[gi].full),
                .drop  (status[gi].drop)
            );

            assign empty_w[gi] = status[gi].empty;
            assign full_w[gi]  = status[gi].full;
            assign drop_w[gi]  = status[gi].drop;
        end
    endgenerate

    always_comb begin
        o_valid    = ~|empty_w;
        o_full     = |full_w;
        o_ready    = ~o_full;
        // A row pops only when every column has data, keeping columns in lockstep.
        pop        = rd & o_valid;
        out_d      = pop ? head_w : out_q;
        overflow_d = overflow_q | (|drop_w);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            overflow_q <= overflow_d;
        end
    end

    assign out      = out_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ofifo.sv
// Randomized and directed bench for ofifo against a queue-based column model.
// A negedge compare process checks every output each cycle; directed steps pin literals.
module tb_ofifo;

    localparam int NC = 8;
    localparam int BW = 16;
    localparam int DP = 16;

    logic                clk;
    logic                reset;
    logic [NC*BW-1:0]    in_v;
    logic [NC-1:0]       wr;
    logic                rd;
    logic [NC*BW-1:0]    out;
    logic                o_valid;
    logic                o_full;
    logic                o_ready;
    logic                overflow;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    ofifo dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in_v),
        .wr       (wr),
        .rd       (rd),
        .out      (out),
        .o_valid  (o_valid),
        .o_full   (o_full),
        .o_ready  (o_ready),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain queues per column, one popped row register, sticky flag.
    logic [BW-1:0]    q [NC][$];
    logic [NC*BW-1:0] m_out;
    logic             m_ovf;
    bit               m_v;
    bit               m_f [NC];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NC; i++) q[i].delete();
            m_out = '0;
            m_ovf = 1'b0;
        end else begin
            m_v = 1'b1;
            for (int i = 0; i < NC; i++) begin
                if (q[i].size() == 0) m_v = 1'b0;
                m_f[i] = (q[i].size() == DP);
            end
            if (rd && m_v) begin
                for (int i = 0; i < NC; i++) m_out[BW*i +: BW] = q[i].pop_front();
            end
            for (int i = 0; i < NC; i++) begin
                if (wr[i]) begin
                    if (m_f[i]) m_ovf = 1'b1;
                    else q[i].push_back(in_v[BW*i +: BW]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [NC*BW-1:0] act, input logic [NC*BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && chk_en) begin
            bit ev;
            bit ef;
            ev = 1'b1;
            ef = 1'b0;
            for (int i = 0; i < NC; i++) begin
                if (q[i].size() == 0) ev = 1'b0;
                if (q[i].size() == DP) ef = 1'b1;
            end
            chk("model_out", out, m_out);
            chk("model_o_valid", {127'b0, o_valid}, {127'b0, ev});
            chk("model_o_full", {127'b0, o_full}, {127'b0, ef});
            chk("model_o_ready", {127'b0, o_ready}, {127'b0, ~ef});
            chk("model_overflow", {127'b0, overflow}, {127'b0, m_ovf});
        end
    end

    function automatic logic [NC*BW-1:0] mkrow(input int base);
        logic [NC*BW-1:0] r;
        for (int i = 0; i < NC; i++) r[BW*i +: BW] = 16'(base + i);
        return r;
    endfunction

    task automatic cyc(input logic [NC-1:0] w, input logic r, input logic [NC*BW-1:0] d);
        wr   = w;
        rd   = r;
        in_v = d;
        @(posedge clk);
        #1;
        wr = '0;
        rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic flag(input string nm, input logic act, input logic exp);
        chk(nm, {127'b0, act}, {127'b0, exp});
    endtask

    logic [NC*BW-1:0] row;

    initial begin
        reset = 1'b0;
        wr    = '0;
        rd    = 1'b0;
        in_v  = '0;
        #12;
        flag("reset_o_valid", o_valid, 1'b0);
        flag("reset_o_full", o_full, 1'b0);
        flag("reset_o_ready", o_ready, 1'b1);
        flag("reset_overflow", overflow, 1'b0);
        chk("reset_out", out, '0);
        @(negedge clk);
        reset  = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // Skewed fill: one more column joins each cycle.
        for (int k = 0; k < NC; k++) begin
            row = '0;
            for (int i = 0; i <= k; i++) row[BW*i +: BW] = 16'(100 + i + 16*(k - i));
            cyc(NC'((1 << (k + 1)) - 1), 1'b0, row);
            if (k == NC - 2) flag("skew_not_valid", o_valid, 1'b0);
        end
        flag("skew_valid", o_valid, 1'b1);
        cyc('0, 1'b1, '0);
        chk("skew_row", out, mkrow(100));
        do_reset();

        // Empty read: column 5 has nothing, so the pop is ignored.
        cyc(8'hDF, 1'b0, mkrow(200));
        flag("empty_not_valid", o_valid, 1'b0);
        cyc('0, 1'b1, '0);
        chk("empty_out_hold", out, '0);
        flag("empty_still_not_valid", o_valid, 1'b0);
        cyc(8'h20, 1'b0, mkrow(300));
        flag("empty_now_valid", o_valid, 1'b1);
        cyc('0, 1'b1, '0);
        row = mkrow(200);
        row[BW*5 +: BW] = 16'd305;
        chk("empty_no_ptr_move", out, row);
        do_reset();

        // Fill column 0, overflow it, then drain in order.
        for (int j = 0; j < DP; j++) cyc(8'h01, 1'b0, (NC*BW)'(j));
        flag("full_o_full", o_full, 1'b1);
        flag("full_o_ready", o_ready, 1'b0);
        flag("full_no_ovf_yet", overflow, 1'b0);
        cyc(8'h01, 1'b0, (NC*BW)'(16'hDEAD));
        flag("full_overflow", overflow, 1'b1);
        for (int j = 0; j < DP; j++) cyc(8'hFE, 1'b0, mkrow(500 + 16*j));
        for (int j = 0; j < DP; j++) begin
            cyc('0, 1'b1, '0);
            chk("full_col0_order", (NC*BW)'(out[BW-1:0]), (NC*BW)'(j));
        end
        flag("full_drained", o_valid, 1'b0);
        do_reset();

        // All columns full, simultaneous pop and write.
        for (int j = 0; j < DP; j++) cyc(8'hFF, 1'b0, mkrow(16*j));
        flag("simul_full", o_full, 1'b1);
        cyc(8'hFF, 1'b1, mkrow(999));
        chk("simul_row0", out, mkrow(0));
        flag("simul_overflow", overflow, 1'b1);
        flag("simul_cnt15_not_full", o_full, 1'b0);
        for (int j = 1; j < DP; j++) begin
            cyc('0, 1'b1, '0);
            chk("simul_rows", out, mkrow(16*j));
        end
        flag("simul_empty", o_valid, 1'b0);
        do_reset();

        // Wrap-around at a steady occupancy of three rows.
        for (int r = 0; r < 3; r++) cyc(8'hFF, 1'b0, mkrow(8*r));
        for (int r = 3; r < 43; r++) begin
            cyc(8'hFF, 1'b1, mkrow(8*r));
            chk("wrap_row", out, mkrow(8*(r - 3)));
            flag("wrap_not_full", o_full, 1'b0);
        end
        do_reset();

        // Random traffic: write-heavy phase then read-heavy phase.
        for (int n = 0; n < 3000; n++) begin
            row = {$urandom, $urandom, $urandom, $urandom};
            if (n < 1500) cyc(NC'($urandom), ($urandom_range(3) == 0), row);
            else          cyc(NC'($urandom), ($urandom_range(3) != 0), row);
        end
        do_reset();

        // Asynchronous reset between edges with data in flight.
        for (int r = 0; r < 3; r++) cyc(8'hFF, 1'b0, mkrow(700 + 8*r));
        cyc('0, 1'b1, '0);
        chk("midreset_pre_out", out, mkrow(700));
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        flag("midreset_o_valid", o_valid, 1'b0);
        flag("midreset_o_full", o_full, 1'b0);
        flag("midreset_o_ready", o_ready, 1'b1);
        flag("midreset_overflow", overflow, 1'b0);
        chk("midreset_out", out, '0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        flag("midreset_discarded", o_valid, 1'b0);
        cyc('0, 1'b1, '0);
        chk("midreset_out_hold", out, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ofifo.md
Name: ofifo

Overview:
Output FIFO directly downstream of mac_row. It captures each column's out_s partial sum when that column's valid bit is asserted. Columns become valid at staggered times because of the systolic skew, so each column has its own FIFO. Reads pop all columns together, which re-aligns one full row of psums for the SFU / memory write-back stage.

Parameters:
col, 8, number of columns (one FIFO per column)
psum_bw, 16, width of one partial sum
depth, 16, entries per column FIFO; must be a power of 2
ptr_bw, 4, log2(depth); pointers are ptr_bw+1 bits wide (extra wrap bit)

Ports:
clk  input  1  clock; everything is rising-edge
reset  input  1  asynchronous, active-low reset
in  input  psum_bw*col  psums from mac_row out_s; column i is in[psum_bw*(i+1)-1:psum_bw*i]
wr  input  col  per-column write enable, driven by mac_row valid; bit i writes column i
rd  input  1  pop one entry from every column
out  output  psum_bw*col  registered row of popped psums; same column packing as in
o_valid  output  1  every column FIFO is non-empty
o_full  output  1  at least one column FIFO is full
o_ready  output  1  equals ~o_full
overflow  output  1  sticky flag: a write was dropped

Behaviour:
- Reset (reset=0, asynchronous):
  - all read/write pointers = 0
  - out = 0, overflow = 0
  - therefore o_valid=0, o_full=0, o_ready=1
- Every release from reset clears all state; any in-flight entries are discarded. Memory contents need no reset.
- Per-column occupancy:
  - cnt_i = wptr_i - rptr_i, modulo 2^(ptr_bw+1)
  - empty_i = (cnt_i == 0)
  - full_i = (wptr_i[ptr_bw] != rptr_i[ptr_bw]) && (wptr_i[ptr_bw-1:0] == rptr_i[ptr_bw-1:0])
- Flags (combinational from the current registered pointers):
  - o_valid = AND over all i of ~empty_i
  - o_full = OR over all i of full_i
- Write, per column, independent of other columns:
  - wr[i]=1 and ~full_i at the edge: mem_i[wptr_i] <= in column i, then wptr_i increments.
  - wr[i]=1 and full_i: the write is dropped and overflow <= 1. This holds even if a pop happens in the same cycle; full is evaluated before the edge.
- Read:
  - rd=1 and o_valid=1 at the edge: out <= {mem_{col-1}[rptr], ..., mem_0[rptr]} and every rptr_i increments. Latency is 1 cycle, from rd sampled to out updated.
  - rd=1 and o_valid=0: ignored. No pointer moves and out holds.
  - rd=0: out holds its last value.
- Simultaneous write and read on the same column:
  - Both take effect; cnt_i is unchanged.
  - A write into an empty column in the same cycle as rd is not visible to that read, because o_valid was 0 pre-edge.
- Wrap-around: pointers wrap naturally modulo 2^(ptr_bw+1). Data order is preserved across the wrap.
- overflow clears only on reset.
- Width rule: psums are stored and output bit-exact. No arithmetic.

Decomposition:
- Shared package: constants COL, PSUM_BW, OFIFO_DEPTH, OFIFO_PTR_BW, shared with mac_row/mac_array top.
- One sub-module, ofifo_col: a single-column FIFO with ports clk, reset, in[psum_bw], wr, rd, out[psum_bw] (head, combinational), empty, full, drop.
- ofifo instantiates col copies via generate. It also contains the AND/OR flag logic, the registered out stage and the sticky overflow register.

Test Plan:
- Reset mid-operation: write 3 rows, pull reset low asynchronously between edges -> o_valid=0, o_full=0, o_ready=1, out=0 immediately, without waiting for a clock edge.
- Skewed fill: wr walks 8'h01, 8'h03, ..., 8'hFF with column i's first value 100+i -> o_valid first goes high the cycle after wr[7]; rd=1 -> next cycle out columns = 100..107.
- Empty read: rd=1 with column 5 empty and all others holding 1 entry -> no pointer moves, out unchanged, o_valid stays 0.
- Full/overflow: 16 writes to column 0 only -> o_full=1, o_ready=0; a 17th write (value 16'hDEAD) -> dropped, overflow=1; after filling the other columns, 16 reads -> column 0 returns 0..15 and never DEAD.
- Wrap-around: 40 rows written and read interleaved with occupancy kept at 3 (wr=8'hFF and rd=1 together) -> every read is in order and equals the value written 3 rows earlier; o_full never asserts.
- Simultaneous read/write at full: all columns full, wr=8'hFF, rd=1 -> read succeeds, writes dropped, overflow=1, every column count becomes 15.
